// File: rtl/dsdmnist_argmax.sv
// Snoops the accelerator's result-buffer writes, reduces each image's 10 class scores
// to a signed argmax and queues {image, digit, score} records for the ARM side.
module dsdmnist_argmax #(
    parameter int IMGNUM     = 10,
    parameter int OAW        = $clog2(IMGNUM * 10),
    parameter int FIFO_DEPTH = 4,
    localparam int IW        = (IMGNUM > 1) ? $clog2(IMGNUM) : 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_n,
    input  logic                  i_CLR,
    input  logic                  i_RESULTBUF_EN,
    input  logic                  i_RESULTBUF_WE,
    input  logic [31:0]           i_RESULTBUF_DATA,
    input  logic [OAW-1:0]        i_RESULTBUF_ADDR,
    output logic                  o_PRED_VALID,
    input  logic                  i_PRED_READY,
    output logic [IW-1:0]         o_PRED_IMGIDX,
    output logic [3:0]            o_PRED_DIGIT,
    output logic [31:0]           o_PRED_SCORE,
    output logic                  o_DONE,
    output logic                  o_OVERFLOW,
    output logic                  o_SEQERR
);

    localparam int CW = $clog2(IMGNUM + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = IW + 4 + 32;

    logic [OAW-1:0]     exp_addr;
    logic [3:0]         cls_cnt;
    logic [CW-1:0]      img_cnt;
    logic signed [31:0] run_max;
    logic [3:0]         run_arg;
    logic               pend_valid;
    logic [RW-1:0]      pend_rec;
    logic               seqerr_q;

    logic [RW-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [NW-1:0]      count;
    logic [CW-1:0]      fin_cnt;
    logic               done_q;
    logic               overflow_q;

    logic               wr;
    logic               seq_bad;
    logic               accept;
    logic signed [31:0] nxt_max;
    logic [3:0]         nxt_arg;
    logic               full;
    logic               pop;
    logic               push;

    assign wr      = i_RESULTBUF_EN & i_RESULTBUF_WE;
    assign seq_bad = wr & ((i_RESULTBUF_ADDR != exp_addr) | done_q);
    assign accept  = wr & ~seq_bad;

    // Class 0 seeds the running max; later classes replace it only on a strictly larger score.
    always_comb begin
        nxt_max = run_max;
        nxt_arg = run_arg;
        if (cls_cnt == 4'd0) begin
            nxt_max = $signed(i_RESULTBUF_DATA);
            nxt_arg = 4'd0;
        end else if ($signed(i_RESULTBUF_DATA) > run_max) begin
            nxt_max = $signed(i_RESULTBUF_DATA);
            nxt_arg = cls_cnt;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            exp_addr   <= '0;
            cls_cnt    <= '0;
            img_cnt    <= '0;
            run_max    <= '0;
            run_arg    <= '0;
            pend_valid <= 1'b0;
            pend_rec   <= '0;
            seqerr_q   <= 1'b0;
        end else if (i_CLR) begin
            exp_addr   <= '0;
            cls_cnt    <= '0;
            img_cnt    <= '0;
            run_max    <= '0;
            run_arg    <= '0;
            pend_valid <= 1'b0;
            pend_rec   <= '0;
            seqerr_q   <= 1'b0;
        end else begin
            pend_valid <= 1'b0;
            if (seq_bad) begin
                seqerr_q <= 1'b1;
            end
            if (accept) begin
                run_max  <= nxt_max;
                run_arg  <= nxt_arg;
                exp_addr <= exp_addr + OAW'(1);
                if (cls_cnt == 4'd9) begin
                    cls_cnt    <= '0;
                    img_cnt    <= img_cnt + CW'(1);
                    pend_valid <= 1'b1;
                    pend_rec   <= {IW'(img_cnt), nxt_arg, nxt_max};
                end else begin
                    cls_cnt <= cls_cnt + 4'd1;
                end
            end
        end
    end

    assign full = (count == NW'(FIFO_DEPTH));
    assign pop  = o_PRED_VALID & i_PRED_READY;
    assign push = pend_valid & (~full | pop);

    // Every finalized record counts toward completion, including ones dropped on a full FIFO.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fin_cnt    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (i_CLR) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fin_cnt    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= pend_rec;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + NW'(1);
            end else if (pop && !push) begin
                count <= count - NW'(1);
            end
            if (pend_valid) begin
                if (!push) begin
                    overflow_q <= 1'b1;
                end
                fin_cnt <= fin_cnt + CW'(1);
                if (fin_cnt == CW'(IMGNUM - 1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o_PRED_VALID = (count != '0);
    assign {o_PRED_IMGIDX, o_PRED_DIGIT, o_PRED_SCORE} = mem[rd_ptr];
    assign o_DONE     = done_q;
    assign o_OVERFLOW = overflow_q;
    assign o_SEQERR   = seqerr_q;

endmodule

// File: tb/tb_dsdmnist_argmax.sv
// Self-checking bench for dsdmnist_argmax: table-driven images plus hand-written
// sequences, with a scoreboard queue of expected prediction records.
module tb_dsdmnist_argmax;

    localparam int IMGNUM = 10;
    localparam int OAW    = 7;
    localparam int IW     = 4;

    typedef struct {
        logic signed [31:0] s [10];
        logic [3:0]         digit;
        logic signed [31:0] score;
    } vec_t;

    typedef struct packed {
        logic [IW-1:0] img;
        logic [3:0]    digit;
        logic [31:0]   score;
    } rec_t;

    logic           i_CLK;
    logic           i_RST_n;
    logic           i_CLR;
    logic           i_RESULTBUF_EN;
    logic           i_RESULTBUF_WE;
    logic [31:0]    i_RESULTBUF_DATA;
    logic [OAW-1:0] i_RESULTBUF_ADDR;
    logic           o_PRED_VALID;
    logic           i_PRED_READY;
    logic [IW-1:0]  o_PRED_IMGIDX;
    logic [3:0]     o_PRED_DIGIT;
    logic [31:0]    o_PRED_SCORE;
    logic           o_DONE;
    logic           o_OVERFLOW;
    logic           o_SEQERR;

    int   checks   = 0;
    int   failures = 0;
    rec_t exp_q [$];
    vec_t tbl [5];

    dsdmnist_argmax #(.IMGNUM(IMGNUM), .OAW(OAW), .FIFO_DEPTH(4)) dut (
        .i_CLK            (i_CLK),
        .i_RST_n          (i_RST_n),
        .i_CLR            (i_CLR),
        .i_RESULTBUF_EN   (i_RESULTBUF_EN),
        .i_RESULTBUF_WE   (i_RESULTBUF_WE),
        .i_RESULTBUF_DATA (i_RESULTBUF_DATA),
        .i_RESULTBUF_ADDR (i_RESULTBUF_ADDR),
        .o_PRED_VALID     (o_PRED_VALID),
        .i_PRED_READY     (i_PRED_READY),
        .o_PRED_IMGIDX    (o_PRED_IMGIDX),
        .o_PRED_DIGIT     (o_PRED_DIGIT),
        .o_PRED_SCORE     (o_PRED_SCORE),
        .o_DONE           (o_DONE),
        .o_OVERFLOW       (o_OVERFLOW),
        .o_SEQERR         (o_SEQERR)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pops happen on the edge after this negedge sample, so each accepted head is compared once.
    always @(negedge i_CLK) begin
        if (i_RST_n && o_PRED_VALID && i_PRED_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_record actual=%0h required=none",
                         {o_PRED_IMGIDX, o_PRED_DIGIT, o_PRED_SCORE});
            end else begin
                check_output("record", 64'({o_PRED_IMGIDX, o_PRED_DIGIT, o_PRED_SCORE}),
                             64'(exp_q.pop_front()));
            end
        end
    end

    task automatic apply_stimulus(input int addr, input logic [31:0] data, input logic we);
        i_RESULTBUF_EN   = 1'b1;
        i_RESULTBUF_WE   = we;
        i_RESULTBUF_ADDR = OAW'(addr);
        i_RESULTBUF_DATA = data;
        @(posedge i_CLK);
        #1;
        i_RESULTBUF_EN   = 1'b0;
        i_RESULTBUF_WE   = 1'b0;
    endtask

    task automatic ref_argmax(input logic signed [31:0] s [10], output logic [3:0] d,
                              output logic signed [31:0] m);
        d = 4'd0;
        m = s[0];
        for (int c = 1; c < 10; c++) begin
            if (s[c] > m) begin
                m = s[c];
                d = 4'(c);
            end
        end
    endtask

    task automatic rand_scores(output logic signed [31:0] s [10]);
        for (int c = 0; c < 10; c++) begin
            s[c] = 32'(int'($urandom_range(40)) - 20);
        end
    endtask

    task automatic write_image(input int img, input logic signed [31:0] s [10], input bit expect_rec,
                               input logic [3:0] d, input logic signed [31:0] m);
        for (int c = 0; c < 10; c++) begin
            if (c == 9 && expect_rec) begin
                exp_q.push_back('{img: IW'(img), digit: d, score: m});
            end
            apply_stimulus(img * 10 + c, s[c], 1'b1);
        end
    endtask

    task automatic write_rand_image(input int img, input bit expect_rec);
        logic signed [31:0] s [10];
        logic [3:0]         d;
        logic signed [31:0] m;
        rand_scores(s);
        ref_argmax(s, d, m);
        write_image(img, s, expect_rec, d, m);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge i_CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge i_CLK);
        #1;
    endtask

    task automatic pulse_clear();
        i_CLR = 1'b1;
        @(posedge i_CLK);
        #1;
        i_CLR = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"},    64'(o_PRED_VALID),  64'(0));
        check_output({tag, "_imgidx"},   64'(o_PRED_IMGIDX), 64'(0));
        check_output({tag, "_digit"},    64'(o_PRED_DIGIT),  64'(0));
        check_output({tag, "_score"},    64'(o_PRED_SCORE),  64'(0));
        check_output({tag, "_done"},     64'(o_DONE),        64'(0));
        check_output({tag, "_overflow"}, 64'(o_OVERFLOW),    64'(0));
        check_output({tag, "_seqerr"},   64'(o_SEQERR),      64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic signed [31:0] s [10];
        logic [3:0]         d;
        logic signed [31:0] m;

        tbl[0].s = '{5, -3, 12, 7, 12, 0, -100, 11, 2, 1};
        tbl[0].digit = 4'd2;  tbl[0].score = 12;
        tbl[1].s = '{-8, -2, -9, -2, -50, -3, -7, -4, -6, -5};
        tbl[1].digit = 4'd1;  tbl[1].score = -2;
        tbl[2].s = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        tbl[2].digit = 4'd9;  tbl[2].score = 9;
        tbl[3].s = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        tbl[3].digit = 4'd0;  tbl[3].score = 7;
        tbl[4].s = '{32'sh8000_0000, 32'sh7fff_ffff, 0, 0, 0, 0, 0, 0, 0, -1};
        tbl[4].digit = 4'd1;  tbl[4].score = 32'sh7fff_ffff;

        i_RST_n = 1'b0;
        i_CLR = 1'b0;
        i_RESULTBUF_EN = 1'b0;
        i_RESULTBUF_WE = 1'b0;
        i_RESULTBUF_DATA = '0;
        i_RESULTBUF_ADDR = '0;
        i_PRED_READY = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge i_CLK);
        i_RST_n = 1'b1;
        @(posedge i_CLK);
        #1;

        // Fixed images 0..4 with READY held high; image 0 also checks first-record latency.
        for (int v = 0; v < 5; v++) begin
            write_image(v, tbl[v].s, 1'b1, tbl[v].digit, tbl[v].score);
            if (v == 0) begin
                check_output("valid_at_edge_k", 64'(o_PRED_VALID), 64'(0));
                @(posedge i_CLK);
                #1;
                check_output("valid_after_edge_k1", 64'(o_PRED_VALID), 64'(1));
            end
        end
        wait_drain(100);
        check_output("done_after_5", 64'(o_DONE), 64'(0));
        check_output("overflow_after_5", 64'(o_OVERFLOW), 64'(0));
        check_output("seqerr_after_5", 64'(o_SEQERR), 64'(0));

        // Image 5: out-of-order address is flagged and ignored, then the image completes.
        rand_scores(s);
        ref_argmax(s, d, m);
        apply_stimulus(50, s[0], 1'b1);
        apply_stimulus(51, s[1], 1'b1);
        apply_stimulus(53, 32'sd99999, 1'b1);
        check_output("seqerr_bad_addr", 64'(o_SEQERR), 64'(1));
        for (int c = 2; c < 10; c++) begin
            if (c == 9) exp_q.push_back('{img: IW'(5), digit: d, score: m});
            apply_stimulus(50 + c, s[c], 1'b1);
        end
        wait_drain(100);

        pulse_clear();
        check_output("clr_seqerr", 64'(o_SEQERR), 64'(0));
        check_output("clr_valid", 64'(o_PRED_VALID), 64'(0));
        apply_stimulus(77, 32'd1, 1'b0);
        check_output("en_without_we", 64'(o_SEQERR), 64'(0));

        // Full run with READY low: only the first four records survive.
        i_PRED_READY = 1'b0;
        for (int img = 0; img < IMGNUM; img++) begin
            write_rand_image(img, img < 4);
        end
        check_output("done_before_last_push", 64'(o_DONE), 64'(0));
        @(posedge i_CLK);
        #1;
        check_output("done_after_last_push", 64'(o_DONE), 64'(1));
        check_output("overflow_run", 64'(o_OVERFLOW), 64'(1));
        check_output("valid_held", 64'(o_PRED_VALID), 64'(1));
        apply_stimulus(100, 32'd3, 1'b1);
        check_output("seqerr_write_after_done", 64'(o_SEQERR), 64'(1));
        i_PRED_READY = 1'b1;
        wait_drain(100);
        check_output("valid_after_drain", 64'(o_PRED_VALID), 64'(0));
        check_output("done_sticky", 64'(o_DONE), 64'(1));

        // Reset mid-image with a record still queued: nothing stale may appear afterwards.
        pulse_clear();
        i_PRED_READY = 1'b0;
        write_rand_image(0, 1'b0);
        rand_scores(s);
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(10 + c, s[c], 1'b1);
        end
        apply_stimulus(40, 32'd5, 1'b1);
        check_output("pre_reset_valid", 64'(o_PRED_VALID), 64'(1));
        check_output("pre_reset_seqerr", 64'(o_SEQERR), 64'(1));
        #2;
        i_RST_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(negedge i_CLK);
        i_RST_n = 1'b1;
        i_PRED_READY = 1'b1;
        @(posedge i_CLK);
        #1;
        write_rand_image(0, 1'b1);
        wait_drain(100);
        check_output("restart_seqerr", 64'(o_SEQERR), 64'(0));

        // FIFO full and popped in the same cycle as the next push.
        pulse_clear();
        i_PRED_READY = 1'b0;
        for (int img = 0; img < 4; img++) begin
            write_rand_image(img, 1'b1);
        end
        check_output("full_valid", 64'(o_PRED_VALID), 64'(1));
        write_rand_image(4, 1'b1);
        i_PRED_READY = 1'b1;
        @(posedge i_CLK);
        #1;
        i_PRED_READY = 1'b0;
        check_output("full_push_pop_overflow", 64'(o_OVERFLOW), 64'(0));
        @(posedge i_CLK);
        #1;
        check_output("queue_len_after_push_pop", 64'(exp_q.size()), 64'(4));
        i_PRED_READY = 1'b1;
        wait_drain(100);
        check_output("final_overflow", 64'(o_OVERFLOW), 64'(0));
        check_output("final_valid", 64'(o_PRED_VALID), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsdmnist_argmax.md
Name: dsdmnist_argmax

Overview:
- Sits directly downstream of the MNIST accelerator top and snoops its result-buffer write port.
- The accelerator emits 10 signed 32-bit class scores per image, at consecutive addresses.
- For each image the block does a running signed argmax over those 10 scores, then pushes {image index, digit, max score} into a small output FIFO.
- The ARM side drains the FIFO through a valid/ready handshake; completion and error flags are sticky.

Parameters:
- IMGNUM, 10, number of images per run; must match the accelerator.
- OAW, $clog2(IMGNUM*10), result-buffer address width.
- FIFO_DEPTH, 4, prediction FIFO entries (power of two, >=2).

Ports:
- i_CLK  in  1  system clock
- i_RST_n  in  1  asynchronous active-low reset
- i_CLR  in  1  synchronous clear of counters, FIFO and sticky flags
- i_RESULTBUF_EN  in  1  result-buffer enable from accelerator
- i_RESULTBUF_WE  in  1  result-buffer write enable
- i_RESULTBUF_DATA  in  32  signed class score
- i_RESULTBUF_ADDR  in  OAW  result-buffer address (image*10 + class)
- o_PRED_VALID  out  1  FIFO head valid
- i_PRED_READY  in  1  consumer accepts head
- o_PRED_IMGIDX  out  $clog2(IMGNUM)  image index of head
- o_PRED_DIGIT  out  4  predicted digit 0..9
- o_PRED_SCORE  out  32  winning score (signed)
- o_DONE  out  1  sticky; IMGNUM records finalized
- o_OVERFLOW  out  1  sticky; record dropped because FIFO full
- o_SEQERR  out  1  sticky; unexpected address or write after done

Behaviour:
- Reset (async, i_RST_n=0): all outputs 0, FIFO empty, expected address 0, class counter 0, image counter 0, running max cleared. i_CLR=1 has the same effect synchronously and has priority over every other event in that cycle.
- Write strobe: wr = i_RESULTBUF_EN & i_RESULTBUF_WE. EN without WE is ignored.
- Address check: an internal expected address exp_addr is compared with i_RESULTBUF_ADDR. On mismatch, or on any wr while o_DONE=1, set o_SEQERR, ignore the write and leave all counters unchanged.
- Accepted write, class 0: max <= data, arg <= 0.
- Accepted write, class c>0: if data > max (signed, strict), then max <= data and arg <= c. Ties keep the lower class index.
- Every accepted write: exp_addr increments and class counter increments. At class 9 the class counter wraps to 0 and the image counter increments.
- Finalize: the class-9 write sampled at edge k is included in the compare. At edge k a pending record {img, arg', max'} is registered. At edge k+1 it is pushed into the FIFO. With the FIFO empty, o_PRED_VALID is high after edge k+1.
- Push is allowed if the FIFO is not full, or if a pop happens in the same cycle (full with simultaneous pop: both occur, count unchanged). Otherwise the record is dropped and o_OVERFLOW is set.
- Pop: on o_PRED_VALID & i_PRED_READY at an edge, the head advances. Output fields are driven from the head register and are stable while valid & !ready. Read/write pointers wrap modulo FIFO_DEPTH.
- Done: the finalize counter counts records, dropped ones included. When it reaches IMGNUM, o_DONE rises on the same edge as the last push. The image counter does not wrap. o_DONE stays high until i_CLR or reset; the FIFO still drains normally afterwards.
- Reset or i_CLR in the middle of an image discards the partial argmax and any pending record.
- Implementation is fully synchronous to i_CLK except the async reset; no combinational path from i_RESULTBUF_* to outputs.

Test Plan:
1. Image 0 scores [5,-3,12,7,12,0,-100,11,2,1] at addr 0..9, READY=1 -> one record: IMGIDX=0, DIGIT=2 (tie goes to lower index), SCORE=12; VALID high after edge k+1 of the addr-9 write; DONE stays 0.
2. All-negative scores [-8,-2,-9,-2,-50,-3,-7,-4,-6,-5] -> DIGIT=1, SCORE=-2, confirming signed compare and tie rule.
3. IMGNUM=10 images back to back, READY=0 -> first 4 records held in order, 6 dropped, OVERFLOW=1, DONE=1 after the 10th finalize; then READY=1 drains images 0..3 and VALID falls.
4. Write to addr 3 when addr 2 is expected -> SEQERR=1, write ignored. A following write to addr 2 is accepted and the image completes correctly.
5. Reset asserted after class 5 of image 1 -> all outputs 0. A restart from addr 0 gives IMGIDX=0 results with no stale record.
6. FIFO full while the head is popped in the same cycle as a push -> no overflow, occupancy stays 4, order preserved; EN=1 with WE=0 at a bad address leaves SEQERR=0.
